// File: rtl/uart_pattern_detect_if.sv
// uart_pattern_detect_if: byte stream in, window/match status out
interface uart_pattern_detect_if #(
  parameter int LEN = 6,
  parameter int CNT_W = 16
);
  logic en;
  logic [7:0] data;
  logic clr_count;
  logic [8*LEN-1:0] buffer;
  logic [$clog2(LEN+1)-1:0] fill;
  logic match;
  logic do_reset;
  logic [CNT_W-1:0] match_count;
  modport master (output en, data, clr_count, input buffer, fill, match, do_reset, match_count);
  modport slave (input en, data, clr_count, output buffer, fill, match, do_reset, match_count);
endinterface

// File: rtl/uart_pattern_detect.sv
// uart_pattern_detect: byte-window pattern matcher with idle timeout, stretched reset request and saturating match count
module uart_pattern_detect #(
  parameter int LEN = 6,
  parameter logic [8*LEN-1:0] PATTERN = "Incorr",
  parameter bit CASE_FOLD = 1'b0,
  parameter int TIMEOUT = 0,
  parameter int RESET_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  uart_pattern_detect_if.slave bus
);
  localparam int FW = $clog2(LEN + 1);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(RESET_CYCLES + 1);
  logic [8*LEN-1:0] r_buf, w_next;
  logic [FW-1:0] r_fill;
  logic [TW-1:0] r_idle;
  logic [SW-1:0] r_str;
  logic [CNT_W-1:0] r_cnt;
  logic r_match;
  logic [LEN-1:0] w_eq;
  logic w_hit, w_to;
  function automatic logic [7:0] fold(input logic [7:0] b);
    return (CASE_FOLD && b >= 8'd65 && b <= 8'd90) ? (b | 8'h20) : b;
  endfunction
  if (LEN == 1) begin : g_one
    assign w_next = bus.data;
  end else begin : g_shift
    assign w_next = {r_buf[8*LEN-9:0], bus.data};
  end
  // compare against the window as it will be after this byte lands
  for (genvar i = 0; i < LEN; i++) begin : g_cmp
    assign w_eq[i] = fold(w_next[8*i +: 8]) == fold(PATTERN[8*i +: 8]);
  end
  assign w_hit = bus.en && (int'(r_fill) + 1 >= LEN) && (&w_eq);
  assign w_to = (TIMEOUT > 0) && !bus.en && (r_fill != '0) && (int'(r_idle) == TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_buf <= '0;
      r_fill <= '0;
      r_idle <= '0;
      r_match <= 1'b0;
      r_str <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= bus.en ? w_next : w_to ? '0 : r_buf;
      r_fill <= bus.en ? ((r_fill == FW'(LEN)) ? r_fill : r_fill + 1'b1) : w_to ? '0 : r_fill;
      r_idle <= (bus.en || w_to || r_fill == '0 || TIMEOUT == 0) ? '0 : r_idle + 1'b1;
      r_match <= w_hit;
      r_str <= w_hit ? SW'(RESET_CYCLES) : (r_str != '0) ? r_str - 1'b1 : r_str;
      r_cnt <= bus.clr_count ? '0 : (w_hit && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  assign bus.buffer = r_buf;
  assign bus.fill = r_fill;
  assign bus.match = r_match;
  assign bus.do_reset = r_str != '0;
  assign bus.match_count = r_cnt;
endmodule
